// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide controller owning the HI/LO registers.
// Multi-cycle mult/multu (and div/divu when MD_DIV_EN is defined) are sequenced by a
// latency down-counter; stall_req holds the D stage while the unit is occupied.
// Optional feature macro: MD_DIV_EN (undefined: ops 3/4 act as none, no divider built).
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    output logic        busy,
    output logic        start,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              signed_q, signed_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic              is_md_op, is_div_op;
    logic [63:0]       ext_a, ext_b, prod;

`ifdef MD_DIV_EN
    logic              div_q, div_d;
    logic              a_neg, b_neg, div_zero;
    logic [31:0]       a_mag, b_mag, quot, rem, quot_res, rem_res;
    assign is_div_op = (E_md_op == 3'd3) || (E_md_op == 3'd4);
`else
    assign is_div_op = 1'b0;
`endif

    // Operation decode and externally visible handshake signals
    always_comb begin
        is_md_op  = (E_md_op == 3'd1) || (E_md_op == 3'd2) || is_div_op;
        busy      = (state_q == StRun);
        start     = is_md_op && !busy;
        stall_req = (start || busy) && D_md_use;
        hi        = hi_q;
        lo        = lo_q;
    end

    // Single 64-bit multiplier: sign- or zero-extending the operands makes the low
    // 64 bits of the unsigned product correct for both mult and multu.
    always_comb begin
        ext_a = signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b = signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = ext_a * ext_b;
    end

`ifdef MD_DIV_EN
    // Sign-magnitude divide; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
    always_comb begin
        a_neg    = signed_q && a_q[31];
        b_neg    = signed_q && b_q[31];
        a_mag    = a_neg ? (32'd0 - a_q) : a_q;
        b_mag    = b_neg ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        quot     = div_zero ? 32'd0 : (a_mag / b_mag);
        rem      = div_zero ? 32'd0 : (a_mag % b_mag);
        quot_res = (a_neg ^ b_neg) ? (32'd0 - quot) : quot;
        rem_res  = a_neg ? (32'd0 - rem) : rem;
    end
`endif

    // Next-state: accept ops in idle, count down in run, commit HI/LO on the last edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MD_DIV_EN
        div_d    = div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    signed_d = (E_md_op == 3'd1) || (E_md_op == 3'd3);
                    a_d      = E_A;
                    b_d      = E_B;
`ifdef MD_DIV_EN
                    div_d    = is_div_op;
                    cnt_d    = is_div_op ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
`else
                    cnt_d    = CntW'(MULT_CYCLES - 1);
`endif
                end else if (E_md_op == 3'd5) begin
                    hi_d = E_A;
                end else if (E_md_op == 3'd6) begin
                    lo_d = E_A;
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
`ifdef MD_DIV_EN
                    if (div_q) begin
                        // Divide by zero leaves HI/LO untouched
                        if (!div_zero) begin
                            hi_d = rem_res;
                            lo_d = quot_res;
                        end
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
`else
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also drops any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MD_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MD_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and randomized checks of md_ctrl against a cycle-level
// reference model that computes results with plain integer arithmetic.
module tb_md_ctrl;

    localparam int unsigned MultCycles = 5;
    localparam int unsigned DivCycles  = 10;
`ifdef MD_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  E_md_op;
    logic [31:0] E_A, E_B;
    logic        D_md_use;
    logic        busy, start, stall_req;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_wr;

    md_ctrl #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .E_md_op  (E_md_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .D_md_use (D_md_use),
        .busy     (busy),
        .start    (start),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_md(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2) || (DivEn && (op == 3'd3 || op == 3'd4));
    endfunction

    // Result of an accepted op, straight from the arithmetic definitions
    task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p, q, r;
        longint unsigned pu;
        p_wr = 1'b1;
        case (op)
            3'd1: begin
                p = longint'(int'(a)) * longint'(int'(b));
                p_hi = p[63:32]; p_lo = p[31:0];
            end
            3'd2: begin
                pu = longint'(a) * longint'(b);
                p_hi = pu[63:32]; p_lo = pu[31:0];
            end
            3'd3: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin
                    q = longint'(int'(a)) / longint'(int'(b));
                    r = longint'(int'(a)) % longint'(int'(b));
                    p_lo = q[31:0]; p_hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin
                    p_lo = a / b; p_hi = a % b;
                end
            end
        endcase
    endtask

    // One clock cycle: drive, compare at negedge, advance model at the edge
    task automatic cyc(input logic r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d);
        bit m_busy, m_start;
        reset = r; E_md_op = op; E_A = a; E_B = b; D_md_use = use_d;
        @(negedge clk);
        m_busy  = (m_left > 0);
        m_start = is_md(op) && !m_busy;
        check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
        check_eq("start", {31'b0, start}, {31'b0, m_start});
        check_eq("stall_req", {31'b0, stall_req}, {31'b0, (m_start || m_busy) && use_d});
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
        @(posedge clk);
        if (r) begin
            m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (m_start) begin
            compute(op, a, b);
            m_left = (op == 3'd3 || op == 3'd4) ? int'(DivCycles) : int'(MultCycles);
        end else if (op == 3'd5) begin
            m_hi = a;
        end else if (op == 3'd6) begin
            m_lo = a;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, use_d);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] lo_keep;
        logic [2:0]  op;
        m_left = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 1'b0;
        reset = 1'b1; E_md_op = 3'd0; E_A = '0; E_B = '0; D_md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cyc(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);

        // mult -3 * 5: busy cycles 1..5, result visible in cycle 6
        cyc(1'b0, 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        for (int k = 1; k <= int'(MultCycles); k++) begin
            check_eq("mult_busy", {31'b0, busy}, 32'd1);
            idle(1, 1'b0);
        end
        check_eq("mult_done", {31'b0, busy}, 32'd0);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFF1);

        // multu with stall request held
        cyc(1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        idle(MultCycles, 1'b1);
        check_eq("multu_stall_end", {31'b0, stall_req}, 32'd0);
        check_eq("multu_hi", hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", lo, 32'h0000_0001);

`ifdef MD_DIV_EN
        cyc(1'b0, 3'd4, 32'd100, 32'd7, 1'b0);
        idle(DivCycles, 1'b0);
        check_eq("divu_lo", lo, 32'd14);
        check_eq("divu_hi", hi, 32'd2);
        cyc(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        idle(4, 1'b1);
        check_eq("div_stall_mid", {31'b0, stall_req}, 32'd1);
        idle(DivCycles - 4, 1'b1);
        check_eq("div_stall_end", {31'b0, stall_req}, 32'd0);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);
        cyc(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DivCycles, 1'b0);
        check_eq("div_ovf_lo", lo, 32'h8000_0000);
        check_eq("div_ovf_hi", hi, 32'd0);
        cyc(1'b0, 3'd5, 32'hA, 32'd0, 1'b0);
        cyc(1'b0, 3'd6, 32'hB, 32'd0, 1'b0);
        cyc(1'b0, 3'd3, 32'd77, 32'd0, 1'b0);
        idle(DivCycles, 1'b0);
        check_eq("div0_hi", hi, 32'hA);
        check_eq("div0_lo", lo, 32'hB);
`else
        E_md_op = 3'd3; E_A = 32'd100; E_B = 32'd7; D_md_use = 1'b1;
        #1;
        check_eq("nodiv_start", {31'b0, start}, 32'd0);
        check_eq("nodiv_stall", {31'b0, stall_req}, 32'd0);
        cyc(1'b0, 3'd4, 32'd100, 32'd7, 1'b1);
        check_eq("nodiv_busy", {31'b0, busy}, 32'd0);
`endif

        // mthi in idle; mtlo during run is ignored
        cyc(1'b0, 3'd5, 32'h1234, 32'd0, 1'b0);
        check_eq("mthi_hi", hi, 32'h1234);
        check_eq("mthi_busy", {31'b0, busy}, 32'd0);
        lo_keep = lo;
        cyc(1'b0, 3'd1, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check_eq("mtlo_run_lo", lo, lo_keep);
        idle(MultCycles, 1'b0);

        // Reset in cycle 3 of a mult discards the result
        cyc(1'b0, 3'd1, 32'd3, 32'd4, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        check_eq("rstmid_busy", {31'b0, busy}, 32'd0);
        check_eq("rstmid_hi", hi, 32'd0);
        check_eq("rstmid_lo", lo, 32'd0);
        idle(8, 1'b0);
        check_eq("rstmid_late_hi", hi, 32'd0);
        check_eq("rstmid_late_lo", lo, 32'd0);

        // Randomized legal traffic: no new mult/div while the unit is busy
        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            if (m_left > 0 && op >= 3'd1 && op <= 3'd4) op = 3'd0;
            cyc(($urandom_range(0, 59) == 0), op, pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
